// File: rtl/mp_avm_bridge_if.sv
// Avalon-MM master-side bus bundle for mp_avm_bridge.
interface mp_avm_bridge_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   m_address;
  logic                m_read;
  logic                m_write;
  logic [DATA_W/8-1:0] m_byteenable;
  logic [DATA_W-1:0]   m_writedata;
  logic                m_waitrequest;
  logic [DATA_W-1:0]   m_readdata;
  logic                m_readdatavalid;

  modport master (
    output m_address, m_read, m_write, m_byteenable, m_writedata,
    input  m_waitrequest, m_readdata, m_readdatavalid
  );

  modport slave (
    input  m_address, m_read, m_write, m_byteenable, m_writedata,
    output m_waitrequest, m_readdata, m_readdatavalid
  );
endinterface

// File: rtl/mp_avm_bridge.sv
// Upstream request FIFO to Avalon-MM master with outstanding-read limiting.
// Optional sticky overflow flag: define MP_AVM_BRIDGE_OVF_FLAG_EN.
module mp_avm_bridge #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 4,
  parameter int MAX_OUTS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                write_en,
  input  logic                read_en,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [DATA_W-1:0]   write_data,
  output logic [DATA_W-1:0]   read_data,
  output logic                read_valid,
  output logic                stall,
  output logic                overflow,
  mp_avm_bridge_if.master     avm
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTS + 1);

  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
  } cmd_t;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [OUT_W-1:0] outs;
  cmd_t             head;
  logic             empty, full, req, push, pop, outs_ok, rd_acc;

  assign head    = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign outs_ok = (outs < OUT_W'(MAX_OUTS));
  assign req     = read_en | write_en;

  // Reads wait at the head when the outstanding limit is hit; nothing behind
  // them may overtake, so ordering is preserved for free.
  assign avm.m_read       = !reset && !empty && !head.is_write && outs_ok;
  assign avm.m_write      = !reset && !empty &&  head.is_write;
  assign avm.m_address    = head.addr;
  assign avm.m_byteenable = head.be;
  assign avm.m_writedata  = head.data;

  assign pop    = (avm.m_read | avm.m_write) && !avm.m_waitrequest;
  assign rd_acc = avm.m_read && !avm.m_waitrequest;
  assign push   = req && (!full || pop);
  assign stall  = (count >= CNT_W'(DEPTH - 1));

  // Storage carries no reset; discarding entries is done via the pointers.
  always_ff @(posedge clock) begin
    if (push && !reset)
      mem[wr_ptr] <= '{is_write: write_en, addr: addr, be: byte_en, data: write_data};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      outs       <= '0;
      read_valid <= 1'b0;
      read_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (rd_acc && !avm.m_readdatavalid)
        outs <= outs + 1'b1;
      else if (!rd_acc && avm.m_readdatavalid && outs != '0)
        outs <= outs - 1'b1;
      read_valid <= avm.m_readdatavalid;
      if (avm.m_readdatavalid) read_data <= avm.m_readdata;
    end
  end

`ifdef MP_AVM_BRIDGE_OVF_FLAG_EN
  logic drop, ovf_q;
  assign drop = req && full && !pop;
  always_ff @(posedge clock) begin
    if (reset)     ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_mp_avm_bridge.sv
// Randomized + directed bench for mp_avm_bridge against a queue-based model.
module tb_mp_avm_bridge;
  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int BW  = DW / 8;
  localparam int DEP = 4;
  localparam int MO  = 2;
`ifdef MP_AVM_BRIDGE_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] addr;
  logic          write_en, read_en;
  logic [BW-1:0] byte_en;
  logic [DW-1:0] write_data, read_data;
  logic          read_valid, stall, overflow;

  mp_avm_bridge_if #(.DATA_W(DW), .ADDR_W(AW)) avm ();

  mp_avm_bridge #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .MAX_OUTS(MO)) dut (
    .clock(clock), .reset(reset), .addr(addr), .write_en(write_en),
    .read_en(read_en), .byte_en(byte_en), .write_data(write_data),
    .read_data(read_data), .read_valid(read_valid), .stall(stall),
    .overflow(overflow), .avm(avm)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] d;
  } req_t;

  req_t          q[$];
  int            outs;
  bit            ovf;
  bit            rv_e;
  logic [DW-1:0] rd_e;
  int            checks, errors;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, compare every output with the model, advance the model.
  task automatic step(input bit rst, input bit we, input bit re, input logic [AW-1:0] a,
                      input logic [BW-1:0] be, input logic [DW-1:0] wd,
                      input bit wt, input bit rdv, input logic [DW-1:0] rdd);
    bit   er, ew, full, pop;
    req_t h;
    @(negedge clock);
    reset = rst; write_en = we; read_en = re; addr = a; byte_en = be; write_data = wd;
    avm.m_waitrequest = wt; avm.m_readdatavalid = rdv; avm.m_readdata = rdd;
    #1;
    er = 0; ew = 0;
    if (!rst && q.size() > 0) begin
      h  = q[0];
      ew = h.w;
      er = !h.w && outs < MO;
    end
    chk("m_read", avm.m_read, er);
    chk("m_write", avm.m_write, ew);
    if (er || ew) begin
      chk("m_address", avm.m_address, h.a);
      chk("m_byteenable", avm.m_byteenable, h.be);
      chk("m_writedata", avm.m_writedata, h.d);
    end
    chk("stall", stall, q.size() >= DEP - 1);
    chk("read_valid", read_valid, rv_e);
    chk("read_data", read_data, rd_e);
    chk("overflow", overflow, ovf && OVF_EN);
    if (rst) begin
      q.delete(); outs = 0; ovf = 0; rv_e = 0; rd_e = '0;
    end else begin
      full = (q.size() == DEP);
      pop  = (er || ew) && !wt;
      if (pop) void'(q.pop_front());
      if (we || re) begin
        if (!full || pop) q.push_back('{we, a, be, wd});
        else ovf = 1;
      end
      if (er && !wt && !rdv) outs++;
      else if (!(er && !wt) && rdv && outs > 0) outs--;
      rv_e = rdv;
      if (rdv) rd_e = rdd;
    end
  endtask

  task automatic idle(input bit wt, input bit rdv = 0, input logic [DW-1:0] rdd = '0);
    step(0, 0, 0, '0, '0, '0, wt, rdv, rdd);
  endtask

  task automatic rd(input logic [AW-1:0] a, input bit wt);
    step(0, 0, 1, a, '1, {$urandom, $urandom}, wt, 0, '0);
  endtask

  task automatic drain();
    int n = 0;
    while ((outs > 0 || q.size() > 0) && n < 50) begin
      idle(0, outs > 0, {$urandom, $urandom});
      n++;
    end
    chk("drain_done", (outs == 0 && q.size() == 0), 1'b1);
  endtask

  initial begin
    reset = 1; write_en = 0; read_en = 0; addr = '0; byte_en = '0; write_data = '0;
    avm.m_waitrequest = 0; avm.m_readdatavalid = 0; avm.m_readdata = '0;
    outs = 0; ovf = 0; rv_e = 0; rd_e = '0; checks = 0; errors = 0;
    repeat (2) @(posedge clock);
    step(1, 0, 0, '0, '0, '0, 0, 0, '0);
    idle(0);

    // single write, no wait
    step(0, 1, 0, 'h7f, 'hff, 'hdeadbeef, 0, 0, '0);
    chk("w_pre", avm.m_write, 0);
    idle(0);
    chk("w_write", avm.m_write, 1);
    chk("w_addr", avm.m_address, 'h7f);
    chk("w_be", avm.m_byteenable, 'hff);
    chk("w_data", avm.m_writedata, 'hdeadbeef);
    idle(0);
    chk("w_once", avm.m_write, 0);

    // read held by waitrequest for 3 cycles, then response
    step(0, 0, 1, 'hff, 'hff, '0, 1, 0, '0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("r_hold", avm.m_read, 1);
      chk("r_addr", avm.m_address, 'hff);
    end
    idle(0);
    chk("r_pop", avm.m_read, 1);
    idle(0);
    chk("r_gone", avm.m_read, 0);
    idle(0, 1, 'hbeefdead);
    idle(0);
    chk("r_valid", read_valid, 1);
    chk("r_data", read_data, 'hbeefdead);
    idle(0);
    chk("r_valid_off", read_valid, 0);
    chk("r_data_hold", read_data, 'hbeefdead);

    // five back-to-back reads with slave stalled: fill and drop
    for (int i = 0; i < 5; i++) begin
      rd(AW'(32'h100 + i), 1);
      chk("f_stall", stall, i >= 3);
    end
    idle(1);
    chk("f_full_stall", stall, 1);
    chk("f_overflow", overflow, OVF_EN);
    drain();

    // outstanding limit of 2 holds the third read
    rd('h200, 0); rd('h201, 0); rd('h202, 0);
    idle(0);
    chk("lim_held0", avm.m_read, 0);
    idle(0);
    chk("lim_held1", avm.m_read, 0);
    idle(0, 1, 'h11);
    chk("lim_held2", avm.m_read, 0);
    idle(0);
    chk("lim_issue", avm.m_read, 1);
    chk("lim_addr", avm.m_address, 'h202);
    drain();

    // reset with 2 queued and 1 outstanding; late response still forwarded
    rd('h300, 0);
    step(0, 1, 0, 'h301, 'h0f, 'h1, 0, 0, '0);
    step(0, 1, 0, 'h302, 'hf0, 'h2, 1, 0, '0);
    chk("pre_rst_q", q.size(), 2);
    step(1, 0, 0, '0, '0, '0, 1, 0, '0);
    idle(0);
    chk("rst_m_read", avm.m_read, 0);
    chk("rst_m_write", avm.m_write, 0);
    chk("rst_rv", read_valid, 0);
    chk("rst_rd", read_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_outs", dut.outs, 0);
    idle(0, 1, 'h1234);
    idle(0);
    chk("late_rv", read_valid, 1);
    chk("late_rd", read_data, 'h1234);
    chk("late_outs", dut.outs, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(99) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0,
           $urandom, $urandom, {$urandom, $urandom}, $urandom_range(2) == 0,
           outs > 0 ? $urandom_range(1) == 1 : $urandom_range(29) == 0,
           {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mp_avm_bridge.md
MP_AVM_BRIDGE -- requirements
Module: mp_avm_bridge

Interface
REQ-001 Parameter DATA_W, default 64, shall set the data word width in bits.
REQ-002 Parameter ADDR_W, default 32, shall set the address width in bits.
REQ-003 Parameter DEPTH, default 4, shall set the command FIFO depth; it shall be a power of 2 and at least 2.
REQ-004 Parameter MAX_OUTS, default 4, shall set the maximum number of outstanding reads; it shall be in the range 1..15.
REQ-005 Ports shall be as follows; one clock, reset synchronous active-high:
 clock  in  1  single clock, rising edge (the multipump 2X clock)
 reset  in  1  synchronous, active-high
 addr  in  ADDR_W  upstream request address
 write_en  in  1  upstream write strobe
 read_en  in  1  upstream read strobe
 byte_en  in  DATA_W/8  upstream byte enables
 write_data  in  DATA_W  upstream write data
 read_data  out  DATA_W  returned read data
 read_valid  out  1  read_data is valid this cycle
 stall  out  1  FIFO almost full; upstream should hold off
 m_address  out  ADDR_W  Avalon-MM master address
 m_read  out  1  Avalon-MM read
 m_write  out  1  Avalon-MM write
 m_byteenable  out  DATA_W/8  Avalon-MM byte enables
 m_writedata  out  DATA_W  Avalon-MM write data
 m_waitrequest  in  1  slave stall
 m_readdata  in  DATA_W  slave read data
 m_readdatavalid  in  1  slave read response strobe
 overflow  out  1  sticky dropped-request flag

Function
REQ-006 A request (read_en or write_en high) shall be pushed into the FIFO as {is_write, addr, byte_en, write_data} when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-007 If read_en and write_en are both high, the request shall be treated as a write and the read shall be discarded.
REQ-008 A request arriving while the FIFO is full with no pop in the same cycle shall be dropped.
REQ-009 The FIFO shall be registered: a push into an empty FIFO shall appear on m_* in the next cycle (1-cycle latency).
REQ-010 When the FIFO is non-empty, the head entry shall drive m_address, m_byteenable and m_writedata, and m_write or m_read shall be asserted according to is_write.
REQ-011 m_* shall remain stable while m_waitrequest is high; the head entry shall pop in the cycle m_read or m_write is high and m_waitrequest is low.
REQ-012 A head read shall not be asserted on m_read while outstanding equals MAX_OUTS; it shall be held in the FIFO, which preserves request order. Writes at the head are unaffected by this limit.
REQ-013 The outstanding counter shall:
 - increment on each accepted read;
 - decrement on m_readdatavalid;
 - stay unchanged when both occur in the same cycle;
 - saturate at 0.
REQ-014 read_data shall register m_readdata and read_valid shall register m_readdatavalid (1-cycle latency); read_data shall hold its last value otherwise.
REQ-015 stall shall be combinational and shall equal (count >= DEPTH-1).
REQ-016 The count shall wrap pointers modulo DEPTH and shall range 0..DEPTH.

Reset
REQ-017 On reset the following shall be cleared, overriding any simultaneous push, pop or response: count, pointers, outstanding, m_read, m_write, read_valid, read_data, overflow.
REQ-018 Queued requests shall be discarded on reset. A response arriving after reset shall still be forwarded on read_data and read_valid, with outstanding saturating at 0.

Configuration
REQ-019 When macro MP_AVM_BRIDGE_OVF_FLAG_EN is defined, overflow shall set on any dropped request (REQ-008) and clear only on reset.
REQ-020 When MP_AVM_BRIDGE_OVF_FLAG_EN is undefined, overflow shall be tied to 0 and no overflow logic shall be built.

Verification
REQ-021 Single write: addr=0x7f, byte_en=0xff, write_data=0xdeadbeef, waitrequest low -> m_write high for exactly 1 cycle, one cycle after the request, with matching fields.
REQ-022 Read with waitrequest held high for 3 cycles -> m_read and m_address=0xff stable for 4 cycles, pop on the 4th; readdatavalid with 0xbeefdead -> read_valid pulse and read_data=0xbeefdead one cycle later.
REQ-023 Five back-to-back reads, waitrequest high, DEPTH=4 -> stall high once count reaches 3; 5th read dropped; overflow=1 with the macro defined and 0 without.
REQ-024 MAX_OUTS=2, three reads accepted with no responses -> 3rd read held off m_read until the first readdatavalid, then issued next cycle.
REQ-025 Reset asserted with 2 entries queued and 1 read outstanding -> all outputs 0 next cycle; a late readdatavalid is forwarded and outstanding stays 0.
